acq_sequencer: RTL and testbench

- Capture controller that sequences the synchronization/trigger datapath and the sample memory for one acquisition.
- Sequence per acquisition:
  - fill the pre-trigger window;
  - arm the trigger and wait for an event, or force one on auto timeout;
  - count post-trigger samples;
  - report the trigger position and the readout start address to the host interface.
- Drives the trigger block's Start_Write and ENABLE_TRIGG inputs and consumes its TRIG_EV_OUT.

---
 rtl/acq_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_acq_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// -----------------------------------------------------------------------------
// acq_sequencer
//
// Capture controller for one acquisition of the sample memory.
// An acquisition runs through these steps:
//   1. Fill the pre-trigger window.
//   2. Arm the trigger block and wait for an event. If enabled, force a
//      trigger after a timeout.
//   3. Count the post-trigger samples.
//   4. Report where the trigger sample landed and where readout should start.
//
// Ports:
//   CLK, RST_N     clock (posedge) and asynchronous active-low reset
//   CLK_EN         sample strobe, one sample per cycle with CLK_EN=1
//   START          one-cycle pulse; accepted only in IDLE or DONE
//   ABORT          return to IDLE on the next edge (highest priority)
//   PRE_CNT        requested pre-trigger sample count
//   POST_CNT       requested post-trigger sample count
//   AUTO_EN        enable the forced trigger on timeout
//   TMO_CNT        timeout length in ARMED samples (0 disables it)
//   TRIG_EV        trigger event, sampled only with CLK_EN=1
//   START_WRITE    high during PRE, ARMED and POST
//   ENABLE_TRIGG   high only in ARMED
//   WR_EN          memory write strobe (combinational)
//   WR_ADDR        registered memory write address, free-running with wrap
//   TRIG_ADDR      address of the trigger sample
//   RD_START       oldest valid sample address (TRIG_ADDR - PRE_EFF mod D)
//   BUSY           acquisition in progress (PRE, ARMED or POST)
//   DONE           acquisition complete, held until START or ABORT
//   FORCED         last trigger came from the timeout
// -----------------------------------------------------------------------------
module acq_sequencer #(
  parameter int ADDR_W = 10,
  parameter int TMO_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLK_EN,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] PRE_CNT,
  input  logic [ADDR_W-1:0] POST_CNT,
  input  logic              AUTO_EN,
  input  logic [TMO_W-1:0]  TMO_CNT,
  input  logic              TRIG_EV,
  output logic              START_WRITE,
  output logic              ENABLE_TRIGG,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic [ADDR_W-1:0] RD_START,
  output logic              BUSY,
  output logic              DONE,
  output logic              FORCED
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_reg,     state_next;
  logic [ADDR_W-1:0] wr_addr_reg,   wr_addr_next;
  logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;
  logic [ADDR_W-1:0] rd_start_reg,  rd_start_next;
  logic [ADDR_W-1:0] pre_eff_reg,   pre_eff_next;
  logic [ADDR_W-1:0] post_eff_reg,  post_eff_next;
  logic [ADDR_W-1:0] cnt_reg,       cnt_next;
  logic [TMO_W-1:0]  tmo_len_reg,   tmo_len_next;
  logic [TMO_W-1:0]  tmo_ctr_reg,   tmo_ctr_next;
  logic              auto_en_reg,   auto_en_next;
  logic              forced_reg,    forced_next;

  logic              capturing;
  logic              wr_en;
  logic [ADDR_W-1:0] cnt_inc;
  logic [TMO_W-1:0]  tmo_inc;
  logic              tmo_active;
  logic              tmo_hit;
  logic [ADDR_W-1:0] pre_limit;
  logic [ADDR_W-1:0] pre_clamped;

  // POST_CNT is ADDR_W wide, so min(POST_CNT, D-1) is POST_CNT itself.
  // D-1-POST_EFF is the bitwise complement in ADDR_W bits.
  assign pre_limit   = ~POST_CNT;
  assign pre_clamped = (PRE_CNT > pre_limit) ? pre_limit : PRE_CNT;

  assign capturing  = (state_reg == S_PRE) || (state_reg == S_ARMED) || (state_reg == S_POST);
  assign wr_en      = CLK_EN & capturing;
  assign cnt_inc    = cnt_reg + ADDR_W'(1);
  assign tmo_inc    = tmo_ctr_reg + TMO_W'(1);
  assign tmo_active = auto_en_reg && (tmo_len_reg != '0);
  assign tmo_hit    = tmo_active && (tmo_inc == tmo_len_reg);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= S_IDLE;
      wr_addr_reg   <= '0;
      trig_addr_reg <= '0;
      rd_start_reg  <= '0;
      pre_eff_reg   <= '0;
      post_eff_reg  <= '0;
      cnt_reg       <= '0;
      tmo_len_reg   <= '0;
      tmo_ctr_reg   <= '0;
      auto_en_reg   <= 1'b0;
      forced_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_addr_reg   <= wr_addr_next;
      trig_addr_reg <= trig_addr_next;
      rd_start_reg  <= rd_start_next;
      pre_eff_reg   <= pre_eff_next;
      post_eff_reg  <= post_eff_next;
      cnt_reg       <= cnt_next;
      tmo_len_reg   <= tmo_len_next;
      tmo_ctr_reg   <= tmo_ctr_next;
      auto_en_reg   <= auto_en_next;
      forced_reg    <= forced_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wr_addr_next   = wr_addr_reg;
    trig_addr_next = trig_addr_reg;
    rd_start_next  = rd_start_reg;
    pre_eff_next   = pre_eff_reg;
    post_eff_next  = post_eff_reg;
    cnt_next       = cnt_reg;
    tmo_len_next   = tmo_len_reg;
    tmo_ctr_next   = tmo_ctr_reg;
    auto_en_next   = auto_en_reg;
    forced_next    = forced_reg;

    // Every strobe seen while capturing lands in memory, whatever the
    // control path decides this cycle. The address therefore always tracks
    // the number of samples actually written.
    if (wr_en) begin
      wr_addr_next = wr_addr_reg + ADDR_W'(1);
    end

    if (ABORT) begin
      state_next  = S_IDLE;
      forced_next = 1'b0;
    end else if (START && ((state_reg == S_IDLE) || (state_reg == S_DONE))) begin
      post_eff_next = POST_CNT;
      pre_eff_next  = pre_clamped;
      auto_en_next  = AUTO_EN;
      tmo_len_next  = TMO_CNT;
      forced_next   = 1'b0;
      cnt_next      = '0;
      tmo_ctr_next  = '0;
      state_next    = (pre_clamped == '0) ? S_ARMED : S_PRE;
    end else if (CLK_EN) begin
      case (state_reg)
        S_PRE: begin
          if (cnt_inc == pre_eff_reg) begin
            cnt_next   = '0;
            state_next = S_ARMED;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        S_ARMED: begin
          if (TRIG_EV || tmo_hit) begin
            trig_addr_next = wr_addr_reg;
            rd_start_next  = wr_addr_reg - pre_eff_reg;
            // A real event on the timeout sample takes precedence.
            forced_next    = !TRIG_EV;
            cnt_next       = '0;
            state_next     = (post_eff_reg == '0) ? S_DONE : S_POST;
          end else if (tmo_active) begin
            tmo_ctr_next = tmo_inc;
          end
        end
        S_POST: begin
          if (cnt_inc == post_eff_reg) begin
            cnt_next   = '0;
            state_next = S_DONE;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign WR_EN        = wr_en;
  assign WR_ADDR      = wr_addr_reg;
  assign TRIG_ADDR    = trig_addr_reg;
  assign RD_START     = rd_start_reg;
  assign START_WRITE  = capturing;
  assign BUSY         = capturing;
  assign ENABLE_TRIGG = (state_reg == S_ARMED);
  assign DONE         = (state_reg == S_DONE);
  assign FORCED       = forced_reg;

endmodule

// File: tb/tb_acq_sequencer.sv
module tb_acq_sequencer;
  localparam int AW = 10;
  localparam int TW = 16;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pre_cnt = '0;
  logic [AW-1:0] post_cnt = '0;
  logic          auto_en = 1'b0;
  logic [TW-1:0] tmo_cnt = '0;
  logic          trig_ev = 1'b0;
  logic          start_write, enable_trigg, wr_en, busy, done, forced;
  logic [AW-1:0] wr_addr, trig_addr, rd_start;

  acq_sequencer #(.ADDR_W(AW), .TMO_W(TW)) dut (
    .CLK(clk), .RST_N(rst_n), .CLK_EN(clk_en), .START(start), .ABORT(abort),
    .PRE_CNT(pre_cnt), .POST_CNT(post_cnt), .AUTO_EN(auto_en), .TMO_CNT(tmo_cnt),
    .TRIG_EV(trig_ev), .START_WRITE(start_write), .ENABLE_TRIGG(enable_trigg),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .TRIG_ADDR(trig_addr), .RD_START(rd_start),
    .BUSY(busy), .DONE(done), .FORCED(forced)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int trig_addr;
    int rd_start;
    bit forced;
    int wr_addr;
    int writes;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   model_addr = 0;
  int   last_trig = 0;
  int   acq_id = 0;
  bit   pat [0:8191];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One acquisition. trig_off is the offset of the real trigger from the
  // first ARMED sample; a negative value means no real trigger is sent.
  // dens: 0 = strobe every cycle, 1 = one cycle in four, 2 = random.
  task automatic run_acq(input int pre, input int post, input bit aen, input int tmo,
                         input int trig_off, input int dens);
    int   pre_e, post_e, t, k, cyc, trig_abs;
    exp_t e;
    post_e = post;
    pre_e  = (pre > D - 1 - post_e) ? D - 1 - post_e : pre;
    trig_abs = (trig_off < 0) ? -1 : pre_e + trig_off;
    for (int i = 0; i < 8192; i++) begin
      if (i < pre_e)          pat[i] = ($urandom_range(0, 3) == 0);
      else if (trig_abs < 0)  pat[i] = 1'b0;
      else if (i < trig_abs)  pat[i] = 1'b0;
      else if (i == trig_abs) pat[i] = 1'b1;
      else                    pat[i] = ($urandom_range(0, 3) == 0);
    end
    // Reference: the trigger is the first ARMED sample carrying an event
    // or completing the timeout count.
    t = pre_e;
    while (t < 8000) begin
      if (pat[t]) break;
      if (aen && tmo != 0 && (t - pre_e + 1) == tmo) break;
      t++;
    end
    e.id        = acq_id++;
    e.trig_addr = (model_addr + t) % D;
    e.rd_start  = (e.trig_addr - pre_e + D) % D;
    e.forced    = !pat[t];
    e.writes    = t + 1 + post_e;
    e.wr_addr   = (model_addr + e.writes) % D;
    sb.push_back(e);
    last_trig  = e.trig_addr;
    model_addr = e.wr_addr;

    pre_cnt  = AW'(pre);
    post_cnt = AW'(post);
    auto_en  = aen;
    tmo_cnt  = TW'(tmo);
    start    = 1'b1;
    clk_en   = 1'($urandom);
    trig_ev  = 1'($urandom);
    step();
    start = 1'b0;
    // Configuration must have been latched by START.
    pre_cnt  = AW'($urandom);
    post_cnt = AW'($urandom);
    auto_en  = 1'($urandom);
    tmo_cnt  = TW'($urandom_range(1, 3));
    k = 0;
    cyc = 0;
    while (k < e.writes) begin
      case (dens)
        0:       clk_en = 1'b1;
        1:       clk_en = (cyc % 4 == 0);
        default: clk_en = 1'($urandom);
      endcase
      if (clk_en) begin
        trig_ev = pat[k];
        k++;
      end else begin
        trig_ev = 1'($urandom);
      end
      step();
      cyc++;
    end
    check("done_after_last_sample", int'(done), 1);
    clk_en  = 1'b0;
    trig_ev = 1'b0;
    step();
  endtask

  // Monitor: counts writes per acquisition and checks each completion
  // against the oldest outstanding expectation.
  initial begin
    int  wcnt;
    bit  done_q;
    exp_t e;
    wcnt   = 0;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_q = 1'b0;
        wcnt   = 0;
      end else begin
        if (start && !busy) wcnt = 0;
        else if (wr_en) wcnt++;
        if (done && !done_q) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got DONE=1, expected no completion");
          end else begin
            e = sb.pop_front();
            check("trig_addr", int'(trig_addr), e.trig_addr);
            check("rd_start",  int'(rd_start),  e.rd_start);
            check("forced",    int'(forced),    int'(e.forced));
            check("wr_addr",   int'(wr_addr),   e.wr_addr);
            check("writes",    wcnt,            e.writes);
            $display("acq %0d: trig_addr=%0d rd_start=%0d forced=%0d wr_addr=%0d writes=%0d",
                     e.id, trig_addr, rd_start, forced, wr_addr, wcnt);
          end
        end
        done_q = done;
      end
    end
  end

  initial begin
    int pre, post, tmo, off, dens, base;
    bit aen;

    // Reset state
    repeat (3) step();
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_busy",    int'(busy),    0);
    check("rst_done",    int'(done),    0);
    check("rst_wr_en",   int'(wr_en),   0);
    rst_n = 1'b1;
    step();

    // Basic capture: trigger on the 7th sample
    run_acq(4, 3, 1'b0, 0, 2, 0);
    check("basic_trig_addr", int'(trig_addr), 6);
    check("basic_rd_start",  int'(rd_start),  2);
    check("basic_wr_addr",   int'(wr_addr),   10);

    // Same capture with a sparse strobe
    run_acq(4, 3, 1'b0, 0, 2, 1);
    check("gated_trig_addr", int'(trig_addr), 16);
    check("gated_wr_addr",   int'(wr_addr),   20);

    // Auto trigger on the 5th ARMED sample, then ABORT from DONE
    run_acq(0, 3, 1'b1, 5, -1, 0);
    check("auto_forced", int'(forced), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_done_clr",   int'(done),      0);
    check("abort_forced_clr", int'(forced),    0);
    check("abort_trig_keep",  int'(trig_addr), last_trig);
    // Real event on the timeout sample wins
    run_acq(0, 3, 1'b1, 5, 4, 0);
    check("auto_real_forced", int'(forced), 0);

    // ABORT in ARMED with a START pulse ignored during PRE
    base = model_addr;
    pre_cnt = 5; post_cnt = 3; auto_en = 1'b0; tmo_cnt = 0;
    start = 1'b1; clk_en = 1'b0;
    step();
    start = 1'b0; clk_en = 1'b1; trig_ev = 1'b1;
    repeat (2) step();
    start = 1'b1; pre_cnt = 1;
    step();
    start = 1'b0;
    repeat (2) step();
    check("pre_start_ignored_armed", int'(enable_trigg), 1);
    trig_ev = 1'b0;
    step();
    abort = 1'b1; clk_en = 1'b0; trig_ev = 1'b1;
    step();
    abort = 1'b0; trig_ev = 1'b0;
    check("armed_abort_busy", int'(busy),      0);
    check("armed_abort_done", int'(done),      0);
    check("armed_abort_addr", int'(wr_addr),   (base + 6) % D);
    check("armed_abort_trig", int'(trig_addr), last_trig);
    model_addr = (base + 6) % D;
    run_acq(2, 2, 1'b0, 0, 1, 2);

    // Wrap and clamp: bring WR_ADDR to 1020, then PRE=1000, POST=1023
    if (model_addr != 1020)
      run_acq(0, (1020 - model_addr - 1 + 2 * D) % D, 1'b0, 0, 0, 0);
    check("wrap_setup_addr", int'(wr_addr), 1020);
    run_acq(1000, 1023, 1'b0, 0, 1, 0);
    check("clamp_trig_addr", int'(trig_addr), 1021);
    check("clamp_rd_start",  int'(rd_start),  1021);

    // Randomized acquisitions
    for (int n = 0; n < 25; n++) begin
      pre  = $urandom_range(0, 12);
      post = $urandom_range(0, 12);
      aen  = 1'($urandom);
      tmo  = $urandom_range(0, 8);
      dens = $urandom_range(0, 2);
      if (aen && tmo != 0 && $urandom_range(0, 1) == 0) off = -1;
      else off = $urandom_range(0, 15);
      run_acq(pre, post, aen, tmo, off, dens);
    end

    // Asynchronous reset in the middle of POST
    pre_cnt = 2; post_cnt = 20; auto_en = 1'b0;
    start = 1'b1; clk_en = 1'b0;
    step();
    start = 1'b0; clk_en = 1'b1; trig_ev = 1'b1;
    repeat (8) step();
    check("mid_post_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wr_addr",   int'(wr_addr),      0);
    check("async_rst_trig_addr", int'(trig_addr),    0);
    check("async_rst_rd_start",  int'(rd_start),     0);
    check("async_rst_start_wr",  int'(start_write),  0);
    check("async_rst_wr_en",     int'(wr_en),        0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_wr_en", int'(wr_en), 0);
    end
    clk_en = 1'b0; trig_ev = 1'b0;
    step();

    while (sb.size() != 0) begin
      void'(sb.pop_front());
      checks++;
      errors++;
      $display("FAIL missing_done: got no completion, expected one");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
